fir_out_serializer: RTL and testbench
=====================================

FIR_OUT_SERIALIZER -- requirements
Module: fir_out_serializer

Interface
REQ-001 SHALL have parameter L, default 3: samples per block produced by the upstream L-parallel FIR; legal range 2..4.
REQ-002 SHALL have parameter DEPTH, default 4: block FIFO depth; power of 2, 2..16.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  block of L outputs presented this cycle.
REQ-006 SHALL have port in_y  input  L x 32 signed  block samples; index 0 = earliest in time (y[Lk]), index L-1 = latest.
REQ-007 SHALL have port in_ready  output  1  FIFO not full; informational, upstream FIR does not stall.
REQ-008 SHALL have port out_valid  output  1  out_data holds a valid sample.
REQ-009 SHALL have port out_ready  input  1  downstream accepts sample.
REQ-010 SHALL have port out_data  output  32 signed  serialized Q31 sample.
REQ-011 SHALL have port out_last  output  1  out_data is lane L-1 of its block.
REQ-012 SHALL have port overflow  output  1  sticky: at least one block dropped.
REQ-013 SHALL have port drop_count  output  16  blocks dropped, saturating at 65535.
REQ-014 SHALL have port level  output  clog2(DEPTH)+1  blocks currently stored.

Function
REQ-015 SHALL store accepted blocks in a DEPTH-entry FIFO of L x 32-bit words, with write pointer, read pointer, and level counter.
REQ-016 SHALL drive in_ready = (level != DEPTH), from registered state only, with no combinational path from out_ready.
REQ-017 SHALL push in_y on a clk edge when in_valid && in_ready.
REQ-018 SHALL drop the block when in_valid && !in_ready, even if a pop occurs in the same cycle; the drop SHALL set overflow and increment drop_count (saturating).
REQ-019 SHALL keep a lane counter 0..L-1 and drive out_data = head_block[lane], out_valid = (level != 0), out_last = out_valid && (lane == L-1).
REQ-020 SHALL advance on a transfer (out_valid && out_ready): lane += 1; when lane == L-1, lane SHALL wrap to 0 and the head block SHALL be popped.
REQ-021 SHALL hold out_data, out_last, and lane stable while out_valid && !out_ready.
REQ-022 SHALL, on simultaneous push and pop, leave level unchanged and advance both pointers.
REQ-023 SHALL wrap the pointers modulo DEPTH.
REQ-024 SHALL give a latency of 1 cycle: a block pushed at edge n into an empty FIFO is presented as lane 0 (out_valid=1) after edge n.
REQ-025 SHALL sustain throughput of 1 sample/cycle with out_ready held high; the FIFO grows when the input block rate exceeds 1/L per cycle.
REQ-026 SHALL pass data unmodified: no rounding, saturation, or sign change.
REQ-027 SHALL ignore in_y when in_valid=0.

Reset
REQ-028 SHALL, on rst assertion (asynchronous), immediately clear pointers, level, lane, overflow, and drop_count, forcing out_valid=0, out_last=0, out_data=0, and in_ready=1.
REQ-029 SHALL discard FIFO contents on a reset mid-operation; no partial block SHALL be emitted after release.
REQ-030 SHALL clear overflow only via rst.
REQ-031 SHALL accept a push on the first clk edge after rst deasserts.

Verification
REQ-032 Single block, L=3: push {100,-200,300}, out_ready=1 -> out_data 100,-200,300 on 3 consecutive cycles; out_last only with 300; then out_valid=0.
REQ-033 Backpressure: push {0x7FFFFFFF,0x80000000,5}, out_ready low 4 cycles after the first sample -> sample 0x80000000 held stable with out_valid=1 for 4 cycles; order preserved, no loss.
REQ-034 Overflow, DEPTH=4: in_valid=1 for 6 consecutive cycles with out_ready=0 -> 4 blocks stored, level=4, in_ready=0, drop_count=2, overflow=1; then 12 samples drained in push order.
REQ-035 Full with simultaneous pop: level=4, out_last transfer coincides with in_valid -> block dropped, drop_count+1, level becomes 3.
REQ-036 Pointer wrap: 20 blocks with distinct values at one block per 3 cycles, out_ready=1 -> 60 samples in exact order, overflow stays 0.
REQ-037 Reset mid-block: assert rst after lane 1 of a block has transferred -> outputs zero at once; after release out_valid=0 until a new push, whose lane 0 appears first.

Source files
------------

// File: rtl/fir_out_serializer.sv
// ---------------------------------------------------------------------------
// fir_out_serializer
//
// Buffers blocks of L parallel Q31 samples coming out of an L-parallel FIR
// and replays them one sample per transfer on a valid/ready stream, lane 0
// (earliest in time) first.  The upstream FIR never stalls.  When the block
// FIFO is full, an arriving block is dropped and counted instead.
//
// Parameters
//   L      samples per block (2..4)
//   DEPTH  block FIFO depth (power of 2, 2..16)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    a block of L samples is presented this cycle
//   in_y        block samples, index 0 = earliest, index L-1 = latest
//   in_ready    FIFO not full (informational only)
//   out_valid   out_data holds a valid sample
//   out_ready   downstream accepts the sample
//   out_data    serialized Q31 sample
//   out_last    out_data is the last lane of its block
//   overflow    sticky flag: at least one block has been dropped
//   drop_count  number of dropped blocks, saturating at 65535
//   level       number of blocks currently stored
// ---------------------------------------------------------------------------
module fir_out_serializer #(
    parameter int L     = 3,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [L-1:0][31:0]     in_y,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [31:0]            out_data,
    output logic                          out_last,
    output logic                          overflow,
    output logic [15:0]                   drop_count,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(L);
    localparam logic [LW-1:0] LANE_LAST = LW'(L - 1);
    localparam logic [PW:0]   LVL_FULL  = (PW + 1)'(DEPTH);

    // Block storage holds data only; it is never reset.
    logic [L-1:0][31:0] mem [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [LW-1:0] lane;

    logic push;
    logic drop;
    logic xfer;
    logic pop;
    logic [L-1:0][31:0] head;

    // in_ready depends on the registered level only, so out_ready never
    // reaches it combinationally.  A pop in the same cycle does not rescue a
    // block arriving at a full FIFO.
    assign in_ready  = (level != LVL_FULL);
    assign push      = in_valid && in_ready;
    assign drop      = in_valid && !in_ready;

    assign out_valid = (level != '0);
    assign xfer      = out_valid && out_ready;
    assign pop       = xfer && (lane == LANE_LAST);

    assign head      = mem[rptr];
    // Output is forced to zero whenever nothing is stored, which also covers
    // the immediate clearing on reset.
    assign out_data  = out_valid ? signed'(head[lane]) : '0;
    assign out_last  = out_valid && (lane == LANE_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_y;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            lane       <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (xfer) begin
                lane <= (lane == LANE_LAST) ? '0 : lane + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_fir_out_serializer
//
// Randomized and directed stimulus for fir_out_serializer (L=3, DEPTH=4).
// A reference model tracks how many samples are stored and appends every
// accepted block's samples to a scoreboard queue; a monitor on the falling
// edge compares each presented sample and the status outputs against it.
// ---------------------------------------------------------------------------
module tb_fir_out_serializer;

    localparam int L     = 3;
    localparam int DEPTH = 4;
    localparam int LVW   = $clog2(DEPTH) + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [L-1:0][31:0]    in_y;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [31:0]    out_data;
    logic                  out_last;
    logic                  overflow;
    logic [15:0]           drop_count;
    logic [LVW-1:0]        level;

    fir_out_serializer #(.L(L), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_y       (in_y),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .overflow   (overflow),
        .drop_count (drop_count),
        .level      (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        last;
    } smp_t;

    smp_t sb[$];
    int   pending;   // samples stored but not yet transferred
    int   m_drops;
    bit   m_ovf;
    int   m_blocks;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the FIFO holds whole blocks; a block occupies a slot
    // until its last sample has been transferred.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pending = 0;
            sb.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
        end else begin
            m_blocks = (pending + L - 1) / L;
            if (pending != 0 && out_ready) pending--;
            if (in_valid) begin
                if (m_blocks != DEPTH) begin
                    for (int i = 0; i < L; i++)
                        sb.push_back('{d: in_y[i], last: (i == L - 1)});
                    pending += L;
                end else begin
                    if (m_drops < 65535) m_drops++;
                    m_ovf = 1'b1;
                end
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            chk("out_valid", out_valid, pending != 0);
            chk("level", level, (pending + L - 1) / L);
            chk("in_ready", in_ready, ((pending + L - 1) / L) != DEPTH);
            chk("drop_count", drop_count, m_drops);
            chk("overflow", overflow, m_ovf);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample got %0h expected none", out_data);
                end else begin
                    chk("out_data", out_data, sb[0].d);
                    chk("out_last", out_last, sb[0].last);
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                chk("idle_data", out_data, 32'd0);
                chk("idle_last", out_last, 1'b0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_y();
        for (int i = 0; i < L; i++) in_y[i] = $urandom;
    endtask

    logic [31:0] first_y;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_y      = '0;
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_level", level, 0);
        cyc(1);
        rst = 1'b0;

        // Single block, pushed on the first edge after reset release
        in_y[0] = 100; in_y[1] = -200; in_y[2] = 300;
        in_valid = 1'b1; out_ready = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        chk("latency_valid", out_valid, 1'b1);
        chk("latency_data", out_data, 32'd100);
        cyc(4);

        // Backpressure on the second sample
        in_y[0] = 32'h7FFFFFFF; in_y[1] = 32'h80000000; in_y[2] = 5;
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(1);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("hold_data", out_data, 32'h80000000);
            chk("hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        cyc(4);

        // Overflow: six blocks into a four-deep FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rand_y();
            in_valid = 1'b1;
            cyc(1);
        end
        in_valid = 1'b0;
        chk("ovf_level", level, 4);
        chk("ovf_in_ready", in_ready, 1'b0);
        chk("ovf_drop_count", drop_count, 2);
        chk("ovf_flag", overflow, 1'b1);
        out_ready = 1'b1;
        cyc(13);

        // Full FIFO with a pop coinciding with an arriving block
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_y();
            in_valid = 1'b1;
            cyc(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc(2);
        chk("fullpop_last", out_last, 1'b1);
        rand_y();
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        chk("fullpop_drop_count", drop_count, 3);
        chk("fullpop_level", level, 3);
        cyc(10);

        // Reset in the middle of a block
        rand_y();
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        cyc(2);
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_data", out_data, 32'd0);
        chk("midrst_last", out_last, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_level", level, 0);
        chk("midrst_drop_count", drop_count, 0);
        chk("midrst_overflow", overflow, 1'b0);
        cyc(1);
        rst = 1'b0;
        cyc(3);
        rand_y();
        first_y = in_y[0];
        in_valid = 1'b1;
        cyc(1);
        in_valid = 1'b0;
        chk("postrst_first", out_data, first_y);
        cyc(4);

        // Pointer wrap: 20 distinct blocks, one every third cycle
        out_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < L; i++) in_y[i] = 32'h1000 + b * 16 + i;
            in_valid = 1'b1;
            cyc(1);
            in_valid = 1'b0;
            cyc(2);
        end
        cyc(5);
        chk("wrap_overflow", overflow, 1'b0);
        chk("wrap_drained", sb.size(), 0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            rand_y();
            in_valid  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc(20);
        chk("random_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
